alu_issue_stage: RTL and testbench

- Upstream issue/writeback stage for the 8-bit datapath ALU.
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Holds a small register file and drives the ALU operands and op bit.
- Captures the ALU result and writes it back to the destination register.
- Serialised: one instruction is in flight at a time, so no hazard logic is needed.

---
 rtl/alu_issue_stage_if.sv | 52 +++++
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 tb/tb_alu_issue_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake and ALU operand/result bus for the issue stage.
// The slave modport is the issue stage; the master modport is its environment
// (the decoder driving instructions plus the combinational ALU).
interface alu_issue_stage_if #(
  parameter int WORD_SIZE  = 8,
  parameter int REG_ADDR_W = 2
);

  // Decoded instruction handshake
  logic                  instr_valid;
  logic                  instr_ready;
  logic [1:0]            instr_opcode;
  logic [REG_ADDR_W-1:0] instr_rd;
  logic [REG_ADDR_W-1:0] instr_rs1;
  logic [REG_ADDR_W-1:0] instr_rs2;
  logic [WORD_SIZE-1:0]  instr_imm;

  // ALU operands out, combinational result back
  logic [WORD_SIZE-1:0]  alu_a;
  logic [WORD_SIZE-1:0]  alu_b;
  logic                  alu_op;
  logic [WORD_SIZE-1:0]  alu_c;

  modport slave (
    input  instr_valid,
    input  instr_opcode,
    input  instr_rd,
    input  instr_rs1,
    input  instr_rs2,
    input  instr_imm,
    input  alu_c,
    output instr_ready,
    output alu_a,
    output alu_b,
    output alu_op
  );

  modport master (
    output instr_valid,
    output instr_opcode,
    output instr_rd,
    output instr_rs1,
    output instr_rs2,
    output instr_imm,
    output alu_c,
    input  instr_ready,
    input  alu_a,
    input  alu_b,
    input  alu_op
  );

endinterface

// File: rtl/alu_issue_stage.sv
// Serialised issue/writeback stage for the 8-bit datapath ALU.
// Accepts one instruction at a time, reads operands from a small register
// file into registered ALU operands, and writes the ALU result back to the
// destination register one cycle later. LDI and NOP bypass the ALU.
module alu_issue_stage #(
  parameter int WORD_SIZE  = 8,
  parameter int NUM_REGS   = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_stage_if.slave      bus,
  output logic                  done,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LDI = 2'b10,
    OP_NOP = 2'b11
  } opcode_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [WORD_SIZE-1:0]  r_regs [NUM_REGS];
  logic [REG_ADDR_W-1:0] r_rd;
  logic [WORD_SIZE-1:0]  r_alu_a;
  logic [WORD_SIZE-1:0]  r_alu_b;
  logic                  r_alu_op;

  opcode_t               w_opcode;
  logic                  w_accept;
  logic                  w_is_alu_op;
  logic                  w_wr_en;
  logic [REG_ADDR_W-1:0] w_wr_addr;
  logic [WORD_SIZE-1:0]  w_wr_data;

  assign w_opcode    = opcode_t'(bus.instr_opcode);
  assign w_accept    = bus.instr_valid && (r_state == S_IDLE);
  assign w_is_alu_op = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

  // Handshake and status outputs depend on state only
  assign bus.instr_ready = (r_state == S_IDLE);
  assign done            = (r_state == S_DONE);

  assign bus.alu_a  = r_alu_a;
  assign bus.alu_b  = r_alu_b;
  assign bus.alu_op = r_alu_op;

  assign dbg_data = r_regs[dbg_addr];

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and single register-file write port selection
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = bus.instr_rd;
    w_wr_data    = bus.instr_imm;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_alu_op) begin
            w_next_state = S_EXEC;
          end else begin
            w_next_state = S_DONE;
            // LDI writes straight from the immediate at the accept edge
            w_wr_en      = (w_opcode == OP_LDI);
          end
        end
      end
      S_EXEC: begin
        // ALU result is combinationally valid while in EXEC
        w_next_state = S_DONE;
        w_wr_en      = 1'b1;
        w_wr_addr    = r_rd;
        w_wr_data    = bus.alu_c;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture at acceptance of ADD/SUB; held at all other times
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 1'b0;
      r_rd     <= '0;
    end else if (w_accept && w_is_alu_op) begin
      // Operands are read before any write from this instruction lands,
      // so rd == rs1/rs2 naturally uses the old value.
      r_alu_a  <= r_regs[bus.instr_rs1];
      r_alu_b  <= r_regs[bus.instr_rs2];
      r_alu_op <= bus.instr_opcode[0];
      r_rd     <= bus.instr_rd;
    end
  end

  // Register file: cleared on reset, one write per cycle
  // NOTE: this storage is a handful of flops with a defined reset value, so
  // resetting it is intended; a RAM-sized array would normally not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a behavioural ALU attached.
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_alu_issue_stage;

  localparam int WORD_SIZE  = 8;
  localparam int NUM_REGS   = 4;
  localparam int REG_ADDR_W = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic                  clk;
  logic                  rst;
  logic                  done;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [WORD_SIZE-1:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage_if #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) bus ();

  // Behavioural 8-bit ALU: add or subtract modulo 256
  assign bus.alu_c = bus.alu_op ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  alu_issue_stage #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done     (done),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational debug read
  task automatic read_reg(input int idx, output logic [WORD_SIZE-1:0] val);
    dbg_addr = REG_ADDR_W'(idx);
    #1;
    val = dbg_data;
  endtask

  // Present an instruction, wait for ready, and return 1 unit after the accept edge
  task automatic send(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm);
    int waited = 0;
    bus.instr_valid  = 1'b1;
    bus.instr_opcode = op;
    bus.instr_rd     = rd;
    bus.instr_rs1    = rs1;
    bus.instr_rs2    = rs2;
    bus.instr_imm    = imm;
    while (bus.instr_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout: ready=%b after %0d cycles, required 1", bus.instr_ready, waited);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [WORD_SIZE-1:0] v;
    do_reset();
    n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.instr_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (bus.alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %h required 00", bus.alu_a); end
    n_checks++; if (bus.alu_b !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b: got %h required 00", bus.alu_b); end
    n_checks++; if (bus.alu_op !== 1'b0) begin n_fail++; $display("FAIL reset_alu_op: got %b required 0", bus.alu_op); end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(i, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h required 00", i, v); end
    end
  endtask

  task automatic test_add();
    logic [WORD_SIZE-1:0] v;
    // LDI r1 = 0x05: done in the cycle right after acceptance
    send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ldi_done: got %b required 1", done); end
    n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL ldi_ready: got %b required 0", bus.instr_ready); end
    read_reg(1, v);
    n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL ldi_r1: got %h required 05", v); end
    send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03);
    // ADD r3 = r1 + r2
    send(OP_ADD, 2'd3, 2'd1, 2'd2, 8'hAA);
    n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec_ready: got %b required 0", bus.instr_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_exec_done: got %b required 0", done); end
    n_checks++; if (bus.alu_a !== 8'h05) begin n_fail++; $display("FAIL add_alu_a: got %h required 05", bus.alu_a); end
    n_checks++; if (bus.alu_b !== 8'h03) begin n_fail++; $display("FAIL add_alu_b: got %h required 03", bus.alu_b); end
    n_checks++; if (bus.alu_op !== 1'b0) begin n_fail++; $display("FAIL add_alu_op: got %b required 0", bus.alu_op); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b required 1", done); end
    n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_done_ready: got %b required 0", bus.instr_ready); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL add_r3: got %h required 08", v); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_idle_done: got %b required 0", done); end
    n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_idle_ready: got %b required 1", bus.instr_ready); end
  endtask

  task automatic test_sub_wrap();
    logic [WORD_SIZE-1:0] v;
    // SUB r0 = r2 - r1 = 0x03 - 0x05 wraps to 0xFE
    send(OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00);
    n_checks++; if (bus.alu_op !== 1'b1) begin n_fail++; $display("FAIL sub_alu_op: got %b required 1", bus.alu_op); end
    n_checks++; if (bus.alu_a !== 8'h03) begin n_fail++; $display("FAIL sub_alu_a: got %h required 03", bus.alu_a); end
    @(posedge clk); #1;
    read_reg(0, v);
    n_checks++; if (v !== 8'hFE) begin n_fail++; $display("FAIL sub_r0: got %h required fe", v); end
    // ADD r0 = 0xFF + 0x01 wraps to 0x00
    send(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hFF);
    send(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h01);
    // LDI leaves the ALU operand registers untouched
    n_checks++; if (bus.alu_op !== 1'b1) begin n_fail++; $display("FAIL ldi_keeps_alu_op: got %b required 1", bus.alu_op); end
    n_checks++; if (bus.alu_b !== 8'h05) begin n_fail++; $display("FAIL ldi_keeps_alu_b: got %h required 05", bus.alu_b); end
    send(OP_ADD, 2'd0, 2'd0, 2'd3, 8'h00);
    n_checks++; if (bus.alu_a !== 8'hFF) begin n_fail++; $display("FAIL wrap_alu_a: got %h required ff", bus.alu_a); end
    n_checks++; if (bus.alu_b !== 8'h01) begin n_fail++; $display("FAIL wrap_alu_b: got %h required 01", bus.alu_b); end
    @(posedge clk); #1;
    read_reg(0, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL wrap_r0: got %h required 00", v); end
  endtask

  task automatic test_self_operand_nop();
    logic [WORD_SIZE-1:0] v;
    logic [WORD_SIZE-1:0] exp_regs [NUM_REGS];
    // ADD r1 = r1 + r1 uses the old r1 for both operands
    send(OP_ADD, 2'd1, 2'd1, 2'd1, 8'h00);
    n_checks++; if (bus.alu_a !== 8'h05 || bus.alu_b !== 8'h05) begin n_fail++; $display("FAIL self_operands: got %h/%h required 05/05", bus.alu_a, bus.alu_b); end
    @(posedge clk); #1;
    read_reg(1, v);
    n_checks++; if (v !== 8'h0A) begin n_fail++; $display("FAIL self_r1: got %h required 0a", v); end
    // NOP retires one cycle after acceptance and writes nothing
    send(OP_NOP, 2'd2, 2'd1, 2'd1, 8'h77);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nop_done: got %b required 1", done); end
    exp_regs = '{8'h00, 8'h0A, 8'h03, 8'h01};
    for (int i = 0; i < NUM_REGS; i++) begin
      read_reg(i, v);
      n_checks++; if (v !== exp_regs[i]) begin n_fail++; $display("FAIL nop_reg%0d: got %h required %h", i, v, exp_regs[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (bus.instr_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL nop_idle: ready=%b done=%b required 1/0", bus.instr_ready, done); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] t_rd  [3] = '{2'd2, 2'd3, 2'd0};
    logic [1:0] t_rs1 [3] = '{2'd1, 2'd1, 2'd2};
    logic [1:0] t_rs2 [3] = '{2'd2, 2'd3, 2'd3};
    int acc_cyc [3];
    int n_acc  = 0;
    int pulses = 0;
    logic was_ready;
    logic [WORD_SIZE-1:0] v;
    // valid stays high; fields only advance after an accept edge
    bus.instr_valid  = 1'b1;
    bus.instr_opcode = OP_SUB;
    bus.instr_imm    = 8'h00;
    bus.instr_rd     = t_rd[0];
    bus.instr_rs1    = t_rs1[0];
    bus.instr_rs2    = t_rs2[0];
    for (int cyc = 0; cyc < 15; cyc++) begin
      was_ready = bus.instr_ready && bus.instr_valid;
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (was_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) begin
          bus.instr_valid = 1'b0;
        end else begin
          bus.instr_rd  = t_rd[n_acc];
          bus.instr_rs1 = t_rs1[n_acc];
          bus.instr_rs2 = t_rs2[n_acc];
        end
      end
    end
    bus.instr_valid = 1'b0;
    n_checks++; if (n_acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", n_acc); end
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 3", pulses); end
    if (n_acc == 3) begin
      n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d,%0d required 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
    end
    // r2 = 0A-03 = 07; r3 = 0A-01 = 09; r0 = 07-09 = FE
    read_reg(2, v);
    n_checks++; if (v !== 8'h07) begin n_fail++; $display("FAIL b2b_r2: got %h required 07", v); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h09) begin n_fail++; $display("FAIL b2b_r3: got %h required 09", v); end
    read_reg(0, v);
    n_checks++; if (v !== 8'hFE) begin n_fail++; $display("FAIL b2b_r0: got %h required fe", v); end
  endtask

  task automatic test_reset_mid_exec();
    logic [WORD_SIZE-1:0] v;
    int pulses = 0;
    do_reset();
    send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05);
    send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03);
    send(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
    n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL rstx_in_exec: ready=%b required 0", bus.instr_ready); end
    // Reset lands on the edge that would have written r3
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (done === 1'b1) pulses++;
    n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rstx_ready: got %b required 1", bus.instr_ready); end
    n_checks++; if (bus.alu_a !== 8'h00) begin n_fail++; $display("FAIL rstx_alu_a: got %h required 00", bus.alu_a); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rstx_r3: got %h required 00", v); end
    read_reg(1, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rstx_r1: got %h required 00", v); end
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstx_done_pulses: got %0d required 0", pulses); end
    read_reg(3, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rstx_r3_later: got %h required 00", v); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.instr_valid  = 1'b0;
    bus.instr_opcode = 2'b00;
    bus.instr_rd     = '0;
    bus.instr_rs1    = '0;
    bus.instr_rs2    = '0;
    bus.instr_imm    = '0;
    dbg_addr         = '0;

    test_reset();
    test_add();
    test_sub_wrap();
    test_self_operand_nop();
    test_back_to_back();
    test_reset_mid_exec();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
